// File: rtl/carry_adder_sched_pkg.sv
// Shared types and constants for the carry-chain adder scheduler.
package carry_sched_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef logic [1:0] byte_idx_t;

endpackage

// File: rtl/carry_adder_sched_if.sv
// Request/response bundle between the two requesters, the scheduler and the result consumer.
interface carry_adder_sched_if #(
    parameter int BYTES = 2
);
    import carry_sched_pkg::*;

    localparam int W = BYTE_W * BYTES;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_sub;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_sub;
    logic         req1_cin;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;
    logic         rsp_zero;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub, req0_cin,
        output req1_valid, req1_a, req1_b, req1_sub, req1_cin,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, rsp_zero,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_sub, req1_cin,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, rsp_zero,
        input  rsp_ready
    );

endinterface

// File: rtl/carry_adder_sched_byte_adder.sv
// Combinational 8-bit ripple adder, one mux-based carry cell per bit.
module carry_byte_adder
    import carry_sched_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] sum,
    output logic              c7,
    output logic              co
);

    logic [BYTE_W-1:0] s;
    logic [BYTE_W:0]   c;

    // Propagate passes the incoming carry; otherwise a (== b) is the generated carry.
    always_comb begin
        s    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < BYTE_W; i++) begin
            c[i+1] = s[i] ? c[i] : a[i];
        end
        sum = s ^ c[BYTE_W-1:0];
    end

    assign c7 = c[BYTE_W-1];
    assign co = c[BYTE_W];

endmodule

// File: rtl/carry_adder_sched.sv
// Round-robin scheduler driving one shared byte adder LSB-first across a multi-byte operation.
module carry_adder_sched
    import carry_sched_pkg::*;
#(
    parameter int BYTES = 2
)
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    carry_adder_sched_if.slave bus
);

    localparam int W = BYTE_W * BYTES;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          id_q, id_d;
    logic          carry_q, carry_d;
    logic          zacc_q, zacc_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          zero_q, zero_d;
    byte_idx_t     idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;

    logic          grant0, grant1;
    logic          sel_sub;
    logic [W-1:0]  sel_b;
    int unsigned   byte_sh;
    logic [BYTE_W-1:0] add_a, add_b, add_s;
    logic          add_c7, add_co;
    logic          zacc_next;

    assign byte_sh = BYTE_W * 32'(idx_q);
    assign add_a   = BYTE_W'(a_q >> byte_sh);
    assign add_b   = BYTE_W'(b_q >> byte_sh);

    carry_byte_adder u_adder (
        .a   (add_a),
        .b   (add_b),
        .ci  (carry_q),
        .sum (add_s),
        .c7  (add_c7),
        .co  (add_co)
    );

    // A lone request wins outright; the pointer only breaks ties.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n && ce && state_q == IDLE) begin
            if (bus.req0_valid && (!bus.req1_valid || !ptr_q)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign sel_sub   = grant1 ? bus.req1_sub : bus.req0_sub;
    assign sel_b     = grant1 ? bus.req1_b : bus.req0_b;
    assign zacc_next = zacc_q & (add_s == '0);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        carry_d = carry_q;
        zacc_d  = zacc_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d     = grant1 ? bus.req1_a : bus.req0_a;
                    b_d     = sel_sub ? ~sel_b : sel_b;
                    carry_d = grant1 ? bus.req1_cin : bus.req0_cin;
                    id_d    = grant1;
                    idx_d   = '0;
                    zacc_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (ce) begin
                    sum_d   = (sum_q & ~(W'({BYTE_W{1'b1}}) << byte_sh))
                            | (W'(add_s) << byte_sh);
                    carry_d = add_co;
                    zacc_d  = zacc_next;
                    if (idx_q == byte_idx_t'(BYTES - 1)) begin
                        cout_d  = add_co;
                        ovf_d   = add_co ^ add_c7;
                        zero_d  = zacc_next;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (ce && bus.rsp_ready) begin
                    ptr_d   = ~id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_sum    = sum_q;
    assign bus.rsp_cout   = cout_q;
    assign bus.rsp_ovf    = ovf_q;
    assign bus.rsp_zero   = zero_q;

endmodule

// File: tb/tb_carry_adder_sched.sv
// Randomized self-checking bench for carry_adder_sched against an arithmetic reference model.
module tb_carry_adder_sched;

    localparam int BYTES = 2;
    localparam int W     = 8 * BYTES;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic ce      = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    carry_adder_sched_if #(.BYTES(BYTES)) bus ();

    carry_adder_sched #(.BYTES(BYTES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // {zero, ovf, cout, sum} from plain W+1 bit arithmetic
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub, input logic cin);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + (W+1)'(cin);
        ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W-1:0] == '0, ovf, full[W], full[W-1:0]};
    endfunction

    task automatic apply_reset();
        reset_n        = 1'b0;
        ce             = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0; bus.req0_cin = 1'b0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0; bus.req1_cin = 1'b0;
        bus.rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drives one request and collects the response; comparisons are left to the callers.
    task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin, input int hold, input int gap,
                         output logic [W+2:0] res, output logic rid, output int lat,
                         output int acc_wait, output logic to, output logic stable,
                         output logic rdy_seen);
        logic acc;
        logic done;
        to = 1'b0; lat = 0; acc_wait = 0; stable = 1'b1; rdy_seen = 1'b0;
        res = '0; rid = 1'b0; acc = 1'b0; done = 1'b0;
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_cin = cin;
            bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_cin = cin;
            bus.req0_valid = 1'b1;
        end
        while (!acc && acc_wait < 20) begin
            @(negedge clk);
            acc = id ? bus.req1_ready : bus.req0_ready;
            @(posedge clk);
            #1;
            acc_wait++;
        end
        if (id) begin
            bus.req1_valid = 1'b0;
            bus.req1_a = W'($urandom); bus.req1_b = W'($urandom); bus.req1_cin = ~cin;
        end else begin
            bus.req0_valid = 1'b0;
            bus.req0_a = W'($urandom); bus.req0_b = W'($urandom); bus.req0_cin = ~cin;
        end
        if (!acc) begin
            to = 1'b1;
            return;
        end
        while (!done && lat < 40) begin
            if (gap > 0 && lat == 0) ce = 1'b0;
            if (lat == gap) ce = 1'b1;
            @(posedge clk);
            #1;
            lat++;
            done = bus.rsp_valid;
        end
        ce = 1'b1;
        if (!done) begin
            to = 1'b1;
            return;
        end
        res = {bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_sum};
        rid = bus.rsp_id;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if ({bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_sum} !== res ||
                bus.rsp_id !== rid || bus.rsp_valid !== 1'b1) stable = 1'b0;
            if (bus.req0_ready || bus.req1_ready) rdy_seen = 1'b1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_sum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b id=%b z=%b v=%b c=%b sum=%h, want all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_sum);
        end
        bus.req0_valid = 1'b1;
        ce = 1'b0;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_ce_low got %b want 0", bus.req0_ready);
        end
        ce = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_idle got r0=%b r1=%b want r0=1 r1=0", bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{16'h00FF, 16'h0000, 16'h7FFF, 16'hFFFF};
        logic [W-1:0] tb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
        logic         ts [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic         ti [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [W+2:0] res, expv;
        logic rid, to, st, rs;
        int lat, aw;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_op(ti[i], ta[i], tb[i], ts[i], tc[i], 0, 0, res, rid, lat, aw, to, st, rs);
            expv = model(ta[i], tb[i], ts[i], tc[i]);
            checks++;
            if (to || res !== expv || rid !== ti[i]) begin
                errors++;
                $display("FAIL directed_%0d got {z,v,c,sum}=%h id=%b to=%b want %h id=%b",
                         i, res, rid, to, expv, ti[i]);
            end
            checks++;
            if (lat != BYTES) begin
                errors++;
                $display("FAIL directed_latency_%0d got %0d want %0d", i, lat, BYTES);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic id, sub, cin, rid, to, st, rs;
        logic [W+2:0] res, expv;
        int lat, aw;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom); b = W'($urandom);
            id = 1'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            if (i % 6 == 0) b = a;
            do_op(id, a, b, sub, cin, 0, 0, res, rid, lat, aw, to, st, rs);
            expv = model(a, b, sub, cin);
            checks++;
            if (to || res !== expv || rid !== id || lat != BYTES) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h sub=%b cin=%b got %h id=%b lat=%0d want %h id=%b lat=%0d",
                         i, a, b, sub, cin, res, rid, lat, expv, id, BYTES);
            end
        end
    endtask

    task automatic test_arbitration();
        logic [W-1:0] a0, b0, a1, b1;
        logic s0, s1, c0, c1;
        logic [3:0] order;
        logic [W+2:0] expv;
        int n, nresp, cyc;
        apply_reset();
        a0 = W'($urandom); b0 = W'($urandom); s0 = 1'($urandom); c0 = 1'($urandom);
        a1 = W'($urandom); b1 = W'($urandom); s1 = 1'($urandom); c1 = 1'($urandom);
        bus.req0_a = a0; bus.req0_b = b0; bus.req0_sub = s0; bus.req0_cin = c0;
        bus.req1_a = a1; bus.req1_b = b1; bus.req1_sub = s1; bus.req1_cin = c1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
        order = '0; n = 0; nresp = 0; cyc = 0;
        while (n < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (bus.req0_ready && bus.req1_ready) begin
                errors++;
                $display("FAIL both_ready got r0=1 r1=1 want at most one");
            end
            if (bus.rsp_valid && nresp < n) begin
                expv = order[nresp] ? model(a1, b1, s1, c1) : model(a0, b0, s0, c0);
                checks++;
                if ({bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_sum} !== expv ||
                    bus.rsp_id !== order[nresp]) begin
                    errors++;
                    $display("FAIL arb_result_%0d got %h id=%b want %h id=%b", nresp,
                             {bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_sum}, bus.rsp_id,
                             expv, order[nresp]);
                end
                nresp++;
            end
            if (bus.req0_ready) begin
                order[n] = 1'b0; n++;
            end else if (bus.req1_ready) begin
                order[n] = 1'b1; n++;
            end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        checks++;
        if (n != 4 || order !== 4'b1010 || nresp != 3) begin
            errors++;
            $display("FAIL arb_order got n=%0d order=%b resp=%0d want n=4 order=1010 resp=3",
                     n, order, nresp);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a0, b0, a1, b1;
        logic rid, to, st, rs, to1, st1, rs1, rid1;
        logic [W+2:0] res, res1;
        int lat, aw, lat1, aw1;
        apply_reset();
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        bus.req1_a = a1; bus.req1_b = b1; bus.req1_sub = 1'b1; bus.req1_cin = 1'b1;
        bus.req1_valid = 1'b1;
        do_op(1'b0, a0, b0, 1'b0, 1'b1, 5, 0, res, rid, lat, aw, to, st, rs);
        checks++;
        if (to || res !== model(a0, b0, 1'b0, 1'b1) || rid !== 1'b0) begin
            errors++;
            $display("FAIL bp_result got %h id=%b to=%b want %h id=0", res, rid, to,
                     model(a0, b0, 1'b0, 1'b1));
        end
        checks++;
        if (st !== 1'b1 || rs !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got stable=%b ready_seen=%b want stable=1 ready_seen=0", st, rs);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_handshake got valid=%b r1=%b want valid=0 r1=1",
                     bus.rsp_valid, bus.req1_ready);
        end
        do_op(1'b1, a1, b1, 1'b1, 1'b1, 0, 0, res1, rid1, lat1, aw1, to1, st1, rs1);
        checks++;
        if (to1 || aw1 != 1 || res1 !== model(a1, b1, 1'b1, 1'b1) || rid1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept got wait=%0d %h id=%b want wait=1 %h id=1",
                     aw1, res1, rid1, model(a1, b1, 1'b1, 1'b1));
        end
    endtask

    task automatic test_ce_stall();
        logic [W-1:0] a, b;
        logic sub, cin, rid, to, st, rs;
        logic [W+2:0] res, expv;
        int lat, aw;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            a = W'($urandom); b = W'($urandom); sub = 1'(i); cin = 1'($urandom);
            do_op(1'(i), a, b, sub, cin, 0, 3, res, rid, lat, aw, to, st, rs);
            expv = model(a, b, sub, cin);
            checks++;
            if (to || res !== expv || rid !== 1'(i) || lat != BYTES + 3) begin
                errors++;
                $display("FAIL ce_stall_%0d got %h id=%b lat=%0d want %h id=%0d lat=%0d",
                         i, res, rid, lat, expv, i, BYTES + 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] a, b;
        logic acc, rid, to, st, rs;
        logic [W+2:0] res, expv;
        int lat, aw, w;
        apply_reset();
        bus.req0_a = 16'h1234; bus.req0_b = 16'h0101; bus.req0_sub = 1'b0; bus.req0_cin = 1'b0;
        bus.req0_valid = 1'b1;
        acc = 1'b0; w = 0;
        while (!acc && w < 20) begin
            @(negedge clk);
            acc = bus.req0_ready;
            @(posedge clk);
            #1;
            w++;
        end
        bus.req0_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (!acc || bus.rsp_sum !== 16'h0035) begin
            errors++;
            $display("FAIL mid_calc_byte0 got acc=%b sum=%h want acc=1 sum=0035", acc, bus.rsp_sum);
        end
        #2;
        bus.req1_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_sum} !== '0 ||
            bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got valid=%b sum=%h c=%b v=%b z=%b r0=%b r1=%b want all 0",
                     bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf, bus.rsp_zero,
                     bus.req0_ready, bus.req1_ready);
        end
        bus.req1_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        a = W'($urandom); b = W'($urandom);
        do_op(1'b1, a, b, 1'b1, 1'b0, 0, 0, res, rid, lat, aw, to, st, rs);
        expv = model(a, b, 1'b1, 1'b0);
        checks++;
        if (to || res !== expv || rid !== 1'b1 || lat != BYTES) begin
            errors++;
            $display("FAIL post_reset_op got %h id=%b lat=%0d want %h id=1 lat=%0d",
                     res, rid, lat, expv, BYTES);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_arbitration();
        test_backpressure();
        test_ce_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/carry_adder_sched.md
# carry_adder_sched

Sequencer and arbiter for the shared 8-bit carry-chain adder in the 6502 datapath. Two requesters submit multi-byte add/subtract operations over valid/ready handshakes. The block arbitrates round-robin and drives the single byte adder once per cycle, LSB first, holding the inter-byte carry in a register. It returns the sum with carry, overflow and zero flags on a valid/ready response port.

## Interface
- BYTES, 2: operand width in bytes; W = 8*BYTES. Legal values 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when low all state is frozen and req0_ready/req1_ready are 0.
- req0_valid, req1_valid  in  1  request valid.
- req0_ready, req1_ready  out  1  request accepted this cycle; combinational, at most one high.
- req0_a, req0_b, req1_a, req1_b  in  W  operands.
- req0_sub, req1_sub  in  1  1 = subtract: b is inverted, and cin acts as not-borrow (6502 SBC).
- req0_cin, req1_cin  in  1  carry into byte 0.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester index of the result.
- rsp_sum  out  W  result.
- rsp_cout  out  1  carry out of the MSB.
- rsp_ovf  out  1  signed overflow: carry into bit W-1 XOR carry out of bit W-1.
- rsp_zero  out  1  1 when rsp_sum == 0.

## Operation
- States: IDLE, CALC, DONE.
- IDLE with ce=1:
  - If exactly one request is valid, that requester is granted.
  - If both are valid, the requester indicated by the priority pointer is granted.
  - The granted req*_ready is driven high. On the edge, a, ~b or b (per sub), cin and id are captured, byte index is set to 0 and zero_acc to 1. Next state is CALC.
- CALC, one cycle per byte:
  - Byte k = byte index is fed to the adder with the carry register.
  - The sum byte is written into rsp_sum[8k+7:8k], carry_reg takes the carry out and zero_acc &= (byte == 0).
  - On the last byte (k = BYTES-1), cout, ovf and zero are registered and the next state is DONE. Otherwise byte index increments.
- DONE: rsp_valid=1, and all rsp_* outputs are stable. On rsp_valid && rsp_ready, next state is IDLE and the pointer is set to the other requester.
- Priority pointer: reset value 0 (req0 first). It changes only on response handshake.
- Request signals are ignored outside IDLE. req*_ready stays 0 in CALC and DONE.
- Operands change after accept: no effect, because they are captured.
- Reset values: state IDLE, pointer 0, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0, rsp_ovf 0, rsp_zero 0, carry_reg 0, ready outputs 0.
- reset_n asserted mid-CALC or mid-DONE: the operation is abandoned with no response, and the block returns to reset values immediately.

## Timing
- Accept edge E0 (IDLE, valid && ready).
- Byte k is registered at edge E(k+1).
- rsp_valid rises after edge E(BYTES), so latency is BYTES cycles from the accept edge.
- The response handshake edge returns the block to IDLE. The next accept is at the earliest on the following edge. Peak throughput is one operation per BYTES+2 cycles.
- ce=0 cycles stretch all latencies 1:1, with no state change.

## Structure
- Package carry_sched_pkg: state enum (IDLE, CALC, DONE); BYTE_W = 8; a type for the byte index counter, 2 bits wide.
- Sub-module carry_byte_adder: combinational 8-bit ripple adder built per bit as s = a^b, c_next = s ? c : a, sum = s ^ c. Ports a[8], b[8], ci, sum[8], c7 (carry into bit 7), co. It is instantiated once, and the scheduler owns all registers.

## Test plan
- BYTES=2, req0: 0x00FF + 0x0001, sub=0, cin=0 -> rsp_sum 0x0100, cout 0, ovf 0, zero 0, id 0; rsp_valid exactly 2 cycles after accept.
- req1: 0x0000 - 0x0001, sub=1, cin=1 -> 0xFFFF, cout 0, ovf 0, zero 0. Then 0x7FFF + 0x0001 -> 0x8000, ovf 1. Then 0xFFFF + 0x0001 -> 0x0000, cout 1, zero 1.
- Both valid, held continuously, rsp_ready=1: grants alternate in the order req0, req1, req0, req1; ready never high for both in one cycle.
- rsp_ready held low 5 cycles in DONE: rsp_* stable and both ready outputs 0 throughout. Handshake, then accept on the next edge.
- ce toggled low for 3 cycles mid-CALC: the result is identical and latency grows by 3.
- reset_n pulsed low mid-CALC: all outputs go to reset values asynchronously. After release, a new req1 operation completes correctly with id 1.
